instr_encoder_loader: RTL and testbench

- Inverse of the instruction control decoder: takes decoded control-signal bundles plus operand fields and encodes them back into 32-bit instruction words.
- Streams the encoded words into instruction memory at consecutive addresses.
- Sits between the test/boot program source and the instruction memory write port.
- Buffers words in a small FIFO and rejects bundles that no legal opcode can produce.

---
 rtl/instr_encoder_loader.sv | 206 ++++++++++++++++++++
 tb/tb_instr_encoder_loader.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: encodes decoded control bundles back into 32-bit
//   instruction words and streams them into instruction memory at consecutive
//   byte addresses (+4 per word) starting from BASE_ADDR.
// Latency: a legal bundle accepted in cycle N is presented on IMEM_WE/WDATA
//   from N+1 onwards; with IMEM_READY held high, one word per cycle.
// Backpressure: IMEM_READY low freezes the write outputs and fills the FIFO;
//   IN_READY drops when the FIFO is full or the session is not running.
//
// Ports:
//   CLK, RESET_N            clock, async active-low reset
//   START, BASE_ADDR        session start pulse and first write address
//   IN_VALID/IN_READY/LAST  bundle handshake, LAST marks the session's final bundle
//   ALUOP..BRAUNCOND        decoded control bundle; RD/RS1/OPB operand fields
//   IMEM_WE/READY/ADDR/WDATA  instruction memory write port
//   BUSY, DONE, ERROR       session status (ERROR sticky per session)
//   WORD_COUNT, ERR_COUNT   words written / bundles rejected this session

// Generic synchronous FIFO; head is visible on pop_dat whenever not empty.
// Latency: one cycle from push to visibility at the head.
// Backpressure: caller must not push when full nor pop when empty.
module fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_vld,
  input  logic [W-1:0] push_dat,
  input  logic         pop_vld,
  output logic [W-1:0] pop_dat,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  // Pointers carry one extra wrap bit to tell full from empty.
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_dat = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_vld) wr_ptr <= wr_ptr + 1'b1;
      if (pop_vld)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: entries are only observed between push and pop.
  always_ff @(posedge clk) begin
    if (push_vld) mem[wr_ptr[AW-1:0]] <= push_dat;
  end
endmodule

module instr_encoder_loader #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 8
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              START,
  input  logic [ADDR_W-1:0] BASE_ADDR,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic              IN_LAST,
  input  logic [2:0]        ALUOP,
  input  logic              MUXIMM,
  input  logic              MOV_SELECT,
  input  logic              BRAZ,
  input  logic              BRANZ,
  input  logic              BRAUNCOND,
  input  logic [7:0]        RD,
  input  logic [7:0]        RS1,
  input  logic [7:0]        OPB,
  output logic              IMEM_WE,
  input  logic              IMEM_READY,
  output logic [ADDR_W-1:0] IMEM_ADDR,
  output logic [31:0]       IMEM_WDATA,
  output logic              BUSY,
  output logic              DONE,
  output logic              ERROR,
  output logic [CNT_W-1:0]  WORD_COUNT,
  output logic [CNT_W-1:0]  ERR_COUNT
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

  state_t      state;
  logic        legal;
  logic [3:0]  opcode;
  logic [31:0] enc_word;
  logic [31:0] head;
  logic        full;
  logic        empty;
  logic        in_fire;
  logic        push;
  logic        pop;
  logic        any_br;
  logic        one_br;

  // ---------------------------------------------------------------- encoder
  assign any_br = BRAZ | BRANZ | BRAUNCOND;
  assign one_br = ({BRANZ, BRAZ, BRAUNCOND} == 3'b100) ||
                  ({BRANZ, BRAZ, BRAUNCOND} == 3'b010) ||
                  ({BRANZ, BRAZ, BRAUNCOND} == 3'b001);

  always_comb begin
    legal  = 1'b0;
    opcode = 4'h0;
    if (!any_br && !MOV_SELECT && !ALUOP[2]) begin
      // Plain ALU ops: opcode packs the ALU function and the immediate select.
      legal  = 1'b1;
      opcode = {1'b0, ALUOP[1:0], MUXIMM};
    end else if (!any_br && MOV_SELECT && (ALUOP == 3'b100) && MUXIMM) begin
      legal  = 1'b1;
      opcode = 4'h8;
    end else if (!MOV_SELECT && one_br) begin
      // Branches ignore ALUOP and MUXIMM entirely.
      legal = 1'b1;
      if (BRANZ)     opcode = 4'h9;
      else if (BRAZ) opcode = 4'hA;
      else           opcode = 4'hB;
    end
  end

  assign enc_word = {4'h0, opcode, RD, RS1, OPB};

  // -------------------------------------------------------------- handshakes
  assign IN_READY   = (state == S_RUN) && !full;
  assign in_fire    = IN_VALID && IN_READY;
  assign push       = in_fire && legal;
  assign IMEM_WE    = !empty && ((state == S_RUN) || (state == S_FLUSH));
  assign pop        = IMEM_WE && IMEM_READY;
  // Gate the data so the write port reads zero whenever no write is offered.
  assign IMEM_WDATA = IMEM_WE ? head : 32'h0;

  fifo #(
    .W     (32),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (CLK),
    .rst_n    (RESET_N),
    .push_vld (push),
    .push_dat (enc_word),
    .pop_vld  (pop),
    .pop_dat  (head),
    .full     (full),
    .empty    (empty)
  );

  // --------------------------------------------------------- session control
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state      <= S_IDLE;
      IMEM_ADDR  <= '0;
      BUSY       <= 1'b0;
      DONE       <= 1'b0;
      ERROR      <= 1'b0;
      WORD_COUNT <= '0;
      ERR_COUNT  <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (START) begin
            state      <= S_RUN;
            IMEM_ADDR  <= BASE_ADDR;
            BUSY       <= 1'b1;
            DONE       <= 1'b0;
            ERROR      <= 1'b0;
            WORD_COUNT <= '0;
            ERR_COUNT  <= '0;
          end
        end
        S_RUN: begin
          // An illegal final bundle still ends the input phase.
          if (in_fire && IN_LAST) state <= S_FLUSH;
        end
        S_FLUSH: begin
          // Empty FIFO means the last write has already been accepted.
          if (empty) begin
            state <= S_DONE;
            BUSY  <= 1'b0;
            DONE  <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase

      // Pops and rejects only happen in RUN/FLUSH, never alongside the clears.
      if (pop) begin
        IMEM_ADDR  <= IMEM_ADDR + ADDR_W'(4);
        WORD_COUNT <= WORD_COUNT + 1'b1;
      end
      if (in_fire && !legal) begin
        ERR_COUNT <= ERR_COUNT + 1'b1;
        ERROR     <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_instr_encoder_loader.sv
module tb_instr_encoder_loader;
  logic        CLK = 1'b0;
  logic        RESET_N;
  logic        START;
  logic [7:0]  BASE_ADDR;
  logic        IN_VALID;
  logic        IN_READY;
  logic        IN_LAST;
  logic [2:0]  ALUOP;
  logic        MUXIMM;
  logic        MOV_SELECT;
  logic        BRAZ;
  logic        BRANZ;
  logic        BRAUNCOND;
  logic [7:0]  RD;
  logic [7:0]  RS1;
  logic [7:0]  OPB;
  logic        IMEM_WE;
  logic        IMEM_READY;
  logic [7:0]  IMEM_ADDR;
  logic [31:0] IMEM_WDATA;
  logic        BUSY;
  logic        DONE;
  logic        ERROR;
  logic [7:0]  WORD_COUNT;
  logic [7:0]  ERR_COUNT;

  always #5 CLK = ~CLK;

  instr_encoder_loader #(
    .ADDR_W (8),
    .DEPTH  (4),
    .CNT_W  (8)
  ) dut (
    .CLK        (CLK),
    .RESET_N    (RESET_N),
    .START      (START),
    .BASE_ADDR  (BASE_ADDR),
    .IN_VALID   (IN_VALID),
    .IN_READY   (IN_READY),
    .IN_LAST    (IN_LAST),
    .ALUOP      (ALUOP),
    .MUXIMM     (MUXIMM),
    .MOV_SELECT (MOV_SELECT),
    .BRAZ       (BRAZ),
    .BRANZ      (BRANZ),
    .BRAUNCOND  (BRAUNCOND),
    .RD         (RD),
    .RS1        (RS1),
    .OPB        (OPB),
    .IMEM_WE    (IMEM_WE),
    .IMEM_READY (IMEM_READY),
    .IMEM_ADDR  (IMEM_ADDR),
    .IMEM_WDATA (IMEM_WDATA),
    .BUSY       (BUSY),
    .DONE       (DONE),
    .ERROR      (ERROR),
    .WORD_COUNT (WORD_COUNT),
    .ERR_COUNT  (ERR_COUNT)
  );

  typedef struct packed {
    logic [7:0]  addr;
    logic [31:0] data;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] next_addr;
  int         n_cmp = 0;
  int         n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Write-side scoreboard: a write completes at the next rising edge.
  always @(negedge CLK) begin
    exp_t e;
    if (RESET_N === 1'b1 && IMEM_WE === 1'b1 && IMEM_READY === 1'b1) begin
      if (sb.size() == 0) begin
        chk("spurious_write", {24'h0, IMEM_ADDR}, 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        chk("write_addr", {24'h0, IMEM_ADDR}, {24'h0, e.addr});
        chk("write_data", IMEM_WDATA, e.data);
      end
    end
  end

  task automatic clear_bundle();
    ALUOP = 3'b000; MUXIMM = 1'b0; MOV_SELECT = 1'b0;
    BRAZ = 1'b0; BRANZ = 1'b0; BRAUNCOND = 1'b0;
    RD = 8'h0; RS1 = 8'h0; OPB = 8'h0; IN_LAST = 1'b0;
  endtask

  task automatic push_exp(input logic [31:0] word);
    exp_t e;
    e.addr = next_addr;
    e.data = word;
    sb.push_back(e);
    next_addr = next_addr + 8'd4;
  endtask

  // Called half a cycle-ish after a rising edge; returns in the same phase.
  task automatic start_session(input logic [7:0] base);
    START = 1'b1;
    BASE_ADDR = base;
    next_addr = base;
    @(posedge CLK); #1;
    START = 1'b0;
    @(negedge CLK);
    chk("start_busy", {31'h0, BUSY}, 32'h1);
    chk("start_done", {31'h0, DONE}, 32'h0);
    chk("start_err", {31'h0, ERROR}, 32'h0);
    chk("start_wcnt", {24'h0, WORD_COUNT}, 32'h0);
    chk("start_ecnt", {24'h0, ERR_COUNT}, 32'h0);
    @(posedge CLK); #1;
  endtask

  task automatic send(input logic [2:0] aluop, input logic muximm, input logic mov,
                      input logic braz, input logic branz, input logic braunc,
                      input logic [7:0] rd, input logic [7:0] rs1, input logic [7:0] opb,
                      input logic last, input logic legal, input logic [3:0] opc);
    bit done_hs = 1'b0;
    ALUOP = aluop; MUXIMM = muximm; MOV_SELECT = mov;
    BRAZ = braz; BRANZ = branz; BRAUNCOND = braunc;
    RD = rd; RS1 = rs1; OPB = opb; IN_LAST = last;
    IN_VALID = 1'b1;
    for (int i = 0; i < 50 && !done_hs; i++) begin
      @(negedge CLK);
      if (IN_READY === 1'b1) begin
        done_hs = 1'b1;
        if (legal) push_exp({4'h0, opc, rd, rs1, opb});
      end
      @(posedge CLK); #1;
    end
    IN_VALID = 1'b0;
    clear_bundle();
    if (!done_hs) chk("send_timeout", 32'h0, 32'h1);
  endtask

  task automatic wait_done(input logic [7:0] exp_w, input logic [7:0] exp_e, input logic exp_err);
    bit seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge CLK);
      if (DONE === 1'b1) seen = 1'b1;
    end
    chk("done_level", {31'h0, DONE}, 32'h1);
    chk("done_busy", {31'h0, BUSY}, 32'h0);
    chk("done_wcnt", {24'h0, WORD_COUNT}, {24'h0, exp_w});
    chk("done_ecnt", {24'h0, ERR_COUNT}, {24'h0, exp_e});
    chk("done_error", {31'h0, ERROR}, {31'h0, exp_err});
    chk("done_sb_empty", 32'(sb.size()), 32'h0);
    @(posedge CLK); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] hold_d;
    logic [7:0]  hold_a;
    int          k;
    RESET_N = 1'b0; START = 1'b0; BASE_ADDR = 8'h0; IN_VALID = 1'b0;
    IMEM_READY = 1'b1; next_addr = 8'h0;
    clear_bundle();
    hold_d = 32'h0; hold_a = 8'h0;

    // Reset state
    repeat (2) @(negedge CLK);
    chk("rst_in_ready", {31'h0, IN_READY}, 32'h0);
    chk("rst_we", {31'h0, IMEM_WE}, 32'h0);
    chk("rst_addr", {24'h0, IMEM_ADDR}, 32'h0);
    chk("rst_wdata", IMEM_WDATA, 32'h0);
    chk("rst_busy", {31'h0, BUSY}, 32'h0);
    chk("rst_done", {31'h0, DONE}, 32'h0);
    chk("rst_error", {31'h0, ERROR}, 32'h0);
    chk("rst_wcnt", {24'h0, WORD_COUNT}, 32'h0);
    chk("rst_ecnt", {24'h0, ERR_COUNT}, 32'h0);
    RESET_N = 1'b1;
    @(posedge CLK); #1;

    // Session 1: add then ori (last)
    start_session(8'h10);
    send(3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h01, 8'h02, 8'h03, 1'b0, 1'b1, 4'h0);
    send(3'b011, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h04, 8'h05, 8'h7F, 1'b1, 1'b1, 4'h7);
    wait_done(8'd2, 8'd0, 1'b0);

    // Session 2: branches ignore ALUOP, mov, and illegal bundles
    start_session(8'h40);
    send(3'b111, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h01, 8'h02, 8'h20, 1'b0, 1'b1, 4'h9);
    send(3'b111, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h03, 8'h04, 8'h20, 1'b0, 1'b1, 4'hA);
    send(3'b111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h05, 8'h06, 8'h20, 1'b0, 1'b1, 4'hB);
    send(3'b100, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h07, 8'h00, 8'h55, 1'b0, 1'b1, 4'h8);
    send(3'b100, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h08, 8'h00, 8'h55, 1'b0, 1'b0, 4'h0);
    send(3'b101, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h09, 8'h01, 8'h02, 1'b0, 1'b0, 4'h0);
    send(3'b000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h0A, 8'h01, 8'h02, 1'b1, 1'b0, 4'h0);
    wait_done(8'd4, 8'd3, 1'b1);

    // Session 3: memory backpressure fills the FIFO, then drains in order
    IMEM_READY = 1'b0;
    start_session(8'h80);
    k = 0;
    ALUOP = 3'b000; RD = 8'h10; RS1 = 8'h20; OPB = 8'h30;
    IN_VALID = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge CLK);
      if (c == 1) begin
        hold_a = IMEM_ADDR;
        hold_d = IMEM_WDATA;
      end
      if (IN_READY === 1'b1) begin
        push_exp({4'h0, 1'b0, ALUOP[1:0], 1'b0, RD, RS1, OPB});
        k++;
      end
      @(posedge CLK); #1;
      ALUOP = 3'(k % 4); RD = 8'h10 + 8'(k); RS1 = 8'h20 + 8'(k); OPB = 8'h30 + 8'(k);
    end
    IN_VALID = 1'b0;
    clear_bundle();
    @(negedge CLK);
    chk("bp_accepted", 32'(k), 32'd4);
    chk("bp_in_ready", {31'h0, IN_READY}, 32'h0);
    chk("bp_we", {31'h0, IMEM_WE}, 32'h1);
    chk("bp_addr", {24'h0, IMEM_ADDR}, 32'h80);
    chk("bp_wdata_head", IMEM_WDATA, 32'h0010_2030);
    chk("bp_addr_stable", {24'h0, IMEM_ADDR}, {24'h0, hold_a});
    chk("bp_wdata_stable", IMEM_WDATA, hold_d);
    @(posedge CLK); #1;
    IMEM_READY = 1'b1;
    send(3'b001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'hAA, 8'hBB, 8'hCC, 1'b1, 1'b1, 4'h3);
    wait_done(8'd5, 8'd0, 1'b0);

    // Session 4: address wrap
    start_session(8'hFC);
    send(3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h11, 8'h12, 8'h13, 1'b0, 1'b1, 4'h4);
    send(3'b010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h21, 8'h22, 8'h23, 1'b0, 1'b1, 4'h5);
    send(3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h31, 8'h32, 8'h33, 1'b1, 1'b1, 4'h2);
    chk("wrap_next_addr", {24'h0, next_addr}, 32'h08);
    wait_done(8'd3, 8'd0, 1'b0);
    chk("wrap_final_addr", {24'h0, IMEM_ADDR}, 32'h08);

    // Session 5: reset with words queued
    IMEM_READY = 1'b0;
    start_session(8'h20);
    send(3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h01, 8'h01, 8'h01, 1'b0, 1'b1, 4'h1);
    send(3'b001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h02, 8'h02, 8'h02, 1'b0, 1'b1, 4'h3);
    send(3'b010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h03, 8'h03, 8'h03, 1'b0, 1'b1, 4'h5);
    chk("prerst_we", {31'h0, IMEM_WE}, 32'h1);
    #2;
    RESET_N = 1'b0;
    #1;
    chk("midrst_we", {31'h0, IMEM_WE}, 32'h0);
    chk("midrst_in_ready", {31'h0, IN_READY}, 32'h0);
    chk("midrst_busy", {31'h0, BUSY}, 32'h0);
    chk("midrst_addr", {24'h0, IMEM_ADDR}, 32'h0);
    chk("midrst_wdata", IMEM_WDATA, 32'h0);
    chk("midrst_wcnt", {24'h0, WORD_COUNT}, 32'h0);
    sb.delete();
    IMEM_READY = 1'b1;
    @(negedge CLK);
    RESET_N = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    chk("postrst_we", {31'h0, IMEM_WE}, 32'h0);
    chk("postrst_done", {31'h0, DONE}, 32'h0);
    start_session(8'h30);
    send(3'b011, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h44, 8'h55, 8'h66, 1'b0, 1'b1, 4'h6);
    send(3'b111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h77, 8'h88, 8'h99, 1'b1, 1'b1, 4'hB);
    wait_done(8'd2, 8'd0, 1'b0);

    chk("final_sb_empty", 32'(sb.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
